// File: rtl/compliance_sig_pkg.sv
// compliance_sig_pkg: register offsets, STATUS field positions and FSM state enum shared by the signature-dump block
package compliance_sig_pkg;
  localparam logic [7:0] OFF_SIG_BEGIN = 8'h00;
  localparam logic [7:0] OFF_SIG_END = 8'h04;
  localparam logic [7:0] OFF_HALT = 8'h08;
  localparam logic [7:0] OFF_STATUS = 8'h0C;
  localparam int STATUS_BUSY = 0;
  localparam int STATUS_DONE = 1;
  localparam int STATUS_CNT_LSB = 16;
  typedef enum logic [2:0] {IDLE, REQ, WAIT, EMIT, DONE} sig_state_e;
endpackage

// File: rtl/compliance_sig_dump_if.sv
// compliance_sig_dump_if: device, host-read and signature-stream signals; slave = controller view, master = system view
interface compliance_sig_dump_if;
  logic dev_req_i;
  logic dev_we_i;
  logic [31:0] dev_addr_i;
  logic [3:0] dev_be_i;
  logic [31:0] dev_wdata_i;
  logic dev_rvalid_o;
  logic [31:0] dev_rdata_o;
  logic dev_err_o;
  logic host_req_o;
  logic host_gnt_i;
  logic [31:0] host_addr_o;
  logic host_rvalid_i;
  logic [31:0] host_rdata_i;
  logic sig_valid_o;
  logic [31:0] sig_data_o;
  logic sig_ready_i;
  logic halt_o;
  modport slave (
    input dev_req_i, dev_we_i, dev_addr_i, dev_be_i, dev_wdata_i, host_gnt_i, host_rvalid_i, host_rdata_i, sig_ready_i,
    output dev_rvalid_o, dev_rdata_o, dev_err_o, host_req_o, host_addr_o, sig_valid_o, sig_data_o, halt_o
  );
  modport master (
    output dev_req_i, dev_we_i, dev_addr_i, dev_be_i, dev_wdata_i, host_gnt_i, host_rvalid_i, host_rdata_i, sig_ready_i,
    input dev_rvalid_o, dev_rdata_o, dev_err_o, host_req_o, host_addr_o, sig_valid_o, sig_data_o, halt_o
  );
endinterface

// File: rtl/compliance_sig_regs.sv
// compliance_sig_regs: device-port decode, SIG_BEGIN/SIG_END storage, STATUS readback, one-cycle error/response and registered halt_pulse
module compliance_sig_regs
  import compliance_sig_pkg::*;
#(
  parameter int DevAddrBits = 10
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        dev_req_i,
  input  logic        dev_we_i,
  input  logic [31:0] dev_addr_i,
  input  logic [3:0]  dev_be_i,
  input  logic [31:0] dev_wdata_i,
  input  logic        busy,
  input  logic        done,
  input  logic [15:0] count,
  output logic        dev_rvalid_o,
  output logic [31:0] dev_rdata_o,
  output logic        dev_err_o,
  output logic [31:0] sig_begin,
  output logic [31:0] sig_end,
  output logic        halt_pulse
);
  logic [DevAddrBits-1:0] off;
  logic [29:0] begin_q, end_q;
  logic is_b, is_e, is_h, is_s, err, wr;
  logic [31:0] status, rdata;
  logic unused_ok;
  assign sig_begin = {begin_q, 2'b00};
  assign sig_end = {end_q, 2'b00};
  assign unused_ok = ^{dev_be_i, dev_addr_i, dev_wdata_i[1:0]};
  always_comb begin
    off = dev_addr_i[DevAddrBits-1:0];
    is_b = off == DevAddrBits'(OFF_SIG_BEGIN);
    is_e = off == DevAddrBits'(OFF_SIG_END);
    is_h = off == DevAddrBits'(OFF_HALT);
    is_s = off == DevAddrBits'(OFF_STATUS);
    err = !(((is_b || is_e) && !(dev_we_i && busy)) || (is_h && dev_we_i) || (is_s && !dev_we_i));
    wr = dev_req_i && dev_we_i && !err;
    status = '0;
    status[STATUS_BUSY] = busy;
    status[STATUS_DONE] = done;
    status[STATUS_CNT_LSB +: 16] = count;
    rdata = (dev_we_i || err) ? '0 : is_b ? sig_begin : is_e ? sig_end : status;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      begin_q <= '0;
      end_q <= '0;
      dev_rvalid_o <= 1'b0;
      dev_err_o <= 1'b0;
      dev_rdata_o <= '0;
      halt_pulse <= 1'b0;
    end else begin
      dev_rvalid_o <= dev_req_i;
      dev_err_o <= dev_req_i && err;
      dev_rdata_o <= dev_req_i ? rdata : '0;
      halt_pulse <= wr && is_h;
      if (wr && is_b) begin_q <= dev_wdata_i[31:2];
      if (wr && is_e) end_q <= dev_wdata_i[31:2];
    end
  end
endmodule

// File: rtl/compliance_sig_dump.sv
// compliance_sig_dump: signature-dump controller (device regs, host reader, valid/ready word stream, halt_o); COMPLIANCE_SIG_DUMP_DISPLAY_EN adds word printing and $finish
module compliance_sig_dump
  import compliance_sig_pkg::*;
#(
  parameter int DevAddrBits = 10,
  parameter int CountWidth = 16
) (
  input logic clk_i,
  input logic rst_ni,
  compliance_sig_dump_if.slave bus
);
  sig_state_e state, state_nxt;
  logic [31:0] ptr, ptr_sum, data_q, sig_begin, sig_end;
  logic [CountWidth-1:0] cnt;
  logic carry, last, step, nonempty, busy, halt_pulse;
  compliance_sig_regs #(.DevAddrBits(DevAddrBits)) u_regs (
    .clk_i(clk_i),
    .rst_ni(rst_ni),
    .dev_req_i(bus.dev_req_i),
    .dev_we_i(bus.dev_we_i),
    .dev_addr_i(bus.dev_addr_i),
    .dev_be_i(bus.dev_be_i),
    .dev_wdata_i(bus.dev_wdata_i),
    .busy(busy),
    .done(state == DONE),
    .count(16'(cnt)),
    .dev_rvalid_o(bus.dev_rvalid_o),
    .dev_rdata_o(bus.dev_rdata_o),
    .dev_err_o(bus.dev_err_o),
    .sig_begin(sig_begin),
    .sig_end(sig_end),
    .halt_pulse(halt_pulse)
  );
  always_comb begin
    {carry, ptr_sum} = {1'b0, ptr} + 33'd4;
    last = carry || ptr_sum >= sig_end;
    nonempty = sig_end > sig_begin;
    step = state == EMIT && bus.sig_ready_i;
    busy = state == REQ || state == WAIT || state == EMIT || (state == IDLE && halt_pulse && nonempty);
    state_nxt = state == IDLE ? (halt_pulse ? (nonempty ? REQ : DONE) : IDLE)
              : state == REQ  ? (bus.host_gnt_i ? WAIT : REQ)
              : state == WAIT ? (bus.host_rvalid_i ? EMIT : WAIT)
              : state == EMIT ? (bus.sig_ready_i ? (last ? DONE : REQ) : EMIT)
              : DONE;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= IDLE;
      ptr <= '0;
      cnt <= '0;
      data_q <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && state_nxt == REQ) ptr <= sig_begin;
      if (step) ptr <= ptr_sum;
      if (step) cnt <= &cnt ? cnt : cnt + CountWidth'(1);
      if (state == WAIT && bus.host_rvalid_i) data_q <= bus.host_rdata_i;
    end
  end
  assign bus.host_req_o = state == REQ;
  assign bus.host_addr_o = ptr;
  assign bus.sig_valid_o = state == EMIT;
  assign bus.sig_data_o = data_q;
  assign bus.halt_o = state == DONE;
`ifdef COMPLIANCE_SIG_DUMP_DISPLAY_EN
  logic shown;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) shown <= 1'b0;
    else begin
      if (step) $display("%08h", data_q);
      if (state == DONE && !shown) $display("signature words: %0d", cnt);
      if (state == DONE) shown <= 1'b1;
      if (shown) $finish;
    end
  end
`else
`endif
endmodule

// File: tb/tb_compliance_sig_dump.sv
// tb_compliance_sig_dump: register vector table plus dump sequences checked against a RAM model and a signature scoreboard
module tb_compliance_sig_dump;
  import compliance_sig_pkg::*;
  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk = ~clk;
  compliance_sig_dump_if bus();
  compliance_sig_dump #(.DevAddrBits(10), .CountWidth(16)) dut (
    .clk_i(clk),
    .rst_ni(rst_ni),
    .bus(bus)
  );
  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mem [logic [31:0]];
  int gnt_delay = 0;
  int gnt_count = 0;
  int stall_req = 0;
  int held_cycles = 0;
  typedef struct {
    bit we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    bit err;
  } vec_t;
  vec_t vt[12];
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask
  initial begin : responder
    int wait_cnt;
    bit granted, in_req;
    logic [31:0] gaddr, req_addr;
    wait_cnt = 0;
    granted = 0;
    in_req = 0;
    gaddr = 0;
    req_addr = 0;
    bus.host_gnt_i = 0;
    bus.host_rvalid_i = 0;
    bus.host_rdata_i = 0;
    forever begin
      @(negedge clk);
      bus.host_gnt_i = 0;
      bus.host_rvalid_i = 0;
      if (granted) begin
        bus.host_rvalid_i = 1;
        bus.host_rdata_i = mem.exists(gaddr) ? mem[gaddr] : ~gaddr;
        granted = 0;
      end else if (bus.host_req_o) begin
        if (in_req) check("host_addr_stable", bus.host_addr_o, req_addr);
        else begin
          in_req = 1;
          req_addr = bus.host_addr_o;
        end
        if (wait_cnt < gnt_delay) wait_cnt++;
        else begin
          bus.host_gnt_i = 1;
          gaddr = bus.host_addr_o;
          granted = 1;
          wait_cnt = 0;
          in_req = 0;
          gnt_count++;
        end
      end
    end
  end
  initial begin : monitor
    int stall;
    bit held;
    logic [31:0] held_data, e;
    stall = 0;
    held = 0;
    held_data = 0;
    bus.sig_ready_i = 0;
    forever begin
      @(negedge clk);
      if (bus.sig_valid_o && stall_req != 0) begin
        stall = 5;
        stall_req = 0;
      end
      bus.sig_ready_i = stall == 0;
      if (stall > 0) begin
        stall--;
        held_cycles++;
      end
      if (bus.sig_valid_o) begin
        if (held) check("sig_data_stable", bus.sig_data_o, held_data);
        if (bus.sig_ready_i) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_word actual=%h required=none", bus.sig_data_o);
          end else begin
            e = exp_q.pop_front();
            check("sig_word", bus.sig_data_o, e);
          end
          held = 0;
        end else begin
          held = 1;
          held_data = bus.sig_data_o;
        end
      end else held = 0;
    end
  end
  task automatic dev_access(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                            output logic [31:0] rdata, output logic err);
    bus.dev_req_i = 1;
    bus.dev_we_i = we;
    bus.dev_addr_i = addr;
    bus.dev_wdata_i = wdata;
    bus.dev_be_i = 4'($urandom);
    @(negedge clk);
    bus.dev_req_i = 0;
    bus.dev_we_i = 0;
    check("dev_rvalid", 32'(bus.dev_rvalid_o), 32'd1);
    rdata = bus.dev_rdata_o;
    err = bus.dev_err_o;
  endtask
  task automatic wr(input string name, input logic [31:0] addr, input logic [31:0] data, input bit exp_err);
    logic [31:0] r;
    logic e;
    dev_access(1, addr, data, r, e);
    check({name, "_err"}, 32'(e), 32'(exp_err));
    check({name, "_rdata"}, r, 32'd0);
  endtask
  task automatic rd(input string name, input logic [31:0] addr, input logic [31:0] exp, input bit exp_err);
    logic [31:0] r;
    logic e;
    dev_access(0, addr, 0, r, e);
    check({name, "_err"}, 32'(e), 32'(exp_err));
    check(name, r, exp);
  endtask
  task automatic check_zero(input string p);
    check({p, "_host_req"}, 32'(bus.host_req_o), 0);
    check({p, "_host_addr"}, bus.host_addr_o, 0);
    check({p, "_sig_valid"}, 32'(bus.sig_valid_o), 0);
    check({p, "_sig_data"}, bus.sig_data_o, 0);
    check({p, "_halt"}, 32'(bus.halt_o), 0);
    check({p, "_dev_rvalid"}, 32'(bus.dev_rvalid_o), 0);
    check({p, "_dev_err"}, 32'(bus.dev_err_o), 0);
    check({p, "_dev_rdata"}, bus.dev_rdata_o, 0);
  endtask
  task automatic do_reset;
    @(negedge clk);
    rst_ni = 0;
    @(negedge clk);
    rst_ni = 1;
    @(negedge clk);
  endtask
  task automatic wait_halt(input int budget);
    for (int i = 0; i < budget && !bus.halt_o; i++) @(negedge clk);
    check("halt_reached", 32'(bus.halt_o), 1);
  endtask
  initial begin : main
    int g0;
    logic [31:0] r;
    logic e;
    bus.dev_req_i = 0;
    bus.dev_we_i = 0;
    bus.dev_addr_i = 0;
    bus.dev_be_i = 0;
    bus.dev_wdata_i = 0;
    vt[0] = '{1'b1, 32'h0000_0000, 32'h0000_1007, 32'h0, 1'b0};
    vt[1] = '{1'b0, 32'h0000_0000, 32'h0, 32'h0000_1004, 1'b0};
    vt[2] = '{1'b1, 32'h0000_0004, 32'h0000_2003, 32'h0, 1'b0};
    vt[3] = '{1'b0, 32'h0000_0004, 32'h0, 32'h0000_2000, 1'b0};
    vt[4] = '{1'b0, 32'h0000_0010, 32'h0, 32'h0, 1'b1};
    vt[5] = '{1'b1, 32'h0000_000C, 32'h55, 32'h0, 1'b1};
    vt[6] = '{1'b0, 32'h0000_0008, 32'h0, 32'h0, 1'b1};
    vt[7] = '{1'b0, 32'h0000_000C, 32'h0, 32'h0, 1'b0};
    vt[8] = '{1'b0, 32'hABCD_E400, 32'h0, 32'h0000_1004, 1'b0};
    vt[9] = '{1'b0, 32'h0000_000E, 32'h0, 32'h0, 1'b1};
    vt[10] = '{1'b1, 32'h0000_040C, 32'h1, 32'h0, 1'b1};
    vt[11] = '{1'b0, 32'hFFFF_FC04, 32'h0, 32'h0000_2000, 1'b0};
    rst_ni = 0;
    repeat (2) @(negedge clk);
    check_zero("reset");
    rst_ni = 1;
    @(negedge clk);
    for (int i = 0; i < 12; i++) begin
      dev_access(vt[i].we, vt[i].addr, vt[i].wdata, r, e);
      check($sformatf("vec%0d_rdata", i), r, vt[i].rdata);
      check($sformatf("vec%0d_err", i), 32'(e), 32'(vt[i].err));
    end
    check("table_no_halt", 32'(bus.halt_o), 0);
    do_reset();
    mem[32'h2000] = 32'h11;
    mem[32'h2004] = 32'h22;
    mem[32'h2008] = 32'h33;
    mem[32'h200C] = 32'h44;
    wr("basic_begin", 32'h0, 32'h2000, 0);
    wr("basic_end", 32'h4, 32'h2010, 0);
    exp_q = '{32'h11, 32'h22, 32'h33, 32'h44};
    g0 = gnt_count;
    wr("basic_halt", 32'h8, 32'h0, 0);
    rd("basic_status_busy", 32'hC, 32'h0000_0001, 0);
    wr("busy_end_write", 32'h4, 32'h5000, 1);
    wr("busy_halt_again", 32'h8, 32'h0, 0);
    rd("busy_end_kept", 32'h4, 32'h2010, 0);
    wr("busy_begin_write", 32'h0, 32'h0, 1);
    wait_halt(100);
    check("basic_words_left", exp_q.size(), 0);
    check("basic_grants", gnt_count - g0, 4);
    rd("basic_status_done", 32'hC, 32'h0004_0002, 0);
    wr("done_halt", 32'h8, 32'h0, 0);
    rd("done_status_kept", 32'hC, 32'h0004_0002, 0);
    do_reset();
    wr("empty_begin", 32'h0, 32'h3000, 0);
    wr("empty_end", 32'h4, 32'h3000, 0);
    g0 = gnt_count;
    dev_access(1, 32'h8, 0, r, e);
    check("empty_halt_err", 32'(e), 0);
    check("empty_halt_at_rvalid", 32'(bus.halt_o), 0);
    @(negedge clk);
    check("empty_halt_after", 32'(bus.halt_o), 1);
    repeat (4) @(negedge clk);
    check("empty_no_req", 32'(bus.host_req_o), 0);
    check("empty_no_grants", gnt_count - g0, 0);
    rd("empty_status", 32'hC, 32'h0000_0002, 0);
    do_reset();
    gnt_delay = 3;
    stall_req = 1;
    held_cycles = 0;
    for (int i = 0; i < 4; i++) begin
      mem[32'h4000 + 4 * i] = $urandom;
      exp_q.push_back(mem[32'h4000 + 4 * i]);
    end
    wr("stall_begin", 32'h0, 32'h4000, 0);
    wr("stall_end", 32'h4, 32'h4010, 0);
    wr("stall_halt", 32'h8, 32'h0, 0);
    wait_halt(300);
    check("stall_words_left", exp_q.size(), 0);
    check("stall_cycles", held_cycles, 5);
    rd("stall_status", 32'hC, 32'h0004_0002, 0);
    gnt_delay = 0;
    do_reset();
    wr("unal_begin", 32'h0, 32'h2003, 0);
    wr("unal_end", 32'h4, 32'h2009, 0);
    rd("unal_begin_rd", 32'h0, 32'h2000, 0);
    rd("unal_end_rd", 32'h4, 32'h2008, 0);
    exp_q = '{32'h11, 32'h22};
    g0 = gnt_count;
    wr("unal_halt", 32'h8, 32'h0, 0);
    wait_halt(100);
    check("unal_words_left", exp_q.size(), 0);
    check("unal_grants", gnt_count - g0, 2);
    rd("unal_status", 32'hC, 32'h0002_0002, 0);
    do_reset();
    wr("rst_begin", 32'h0, 32'h2000, 0);
    wr("rst_end", 32'h4, 32'h2010, 0);
    exp_q = '{32'h11};
    wr("rst_halt", 32'h8, 32'h0, 0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #1;
      if (bus.host_gnt_i) break;
    end
    check("rst_gnt_seen", 32'(bus.host_gnt_i), 1);
    @(posedge clk);
    #1;
    rst_ni = 0;
    #1;
    check_zero("midreset");
    exp_q.delete();
    #1;
    rst_ni = 1;
    repeat (3) @(negedge clk);
    check("rst_rvalid_ignored", 32'(bus.sig_valid_o), 0);
    check("rst_no_halt", 32'(bus.halt_o), 0);
    rd("rst_begin_zero", 32'h0, 32'h0, 0);
    mem[32'h0] = 32'hA0;
    mem[32'h4] = 32'hA4;
    wr("rst_end8", 32'h4, 32'h8, 0);
    exp_q = '{32'hA0, 32'hA4};
    wr("rst_halt2", 32'h8, 32'h0, 0);
    wait_halt(100);
    check("rst_words_left", exp_q.size(), 0);
    rd("rst_status", 32'hC, 32'h0002_0002, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
